// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full adder (two half adders) swept over WIDTH cycles,
// with valid/ready handshakes on operands and result. Optional signed overflow
// flag is enabled by defining SERIAL_ADD_OVERFLOW_EN.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef SERIAL_ADD_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, res;
  logic [CNT_W-1:0]   cnt;
  logic               carry, cout_q;
  logic [1:0]         ha1, ha2;
  logic               bit_sum, carry_nxt, last_bit;

  // Returns {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    ha1       = half_add(a_q[cnt], b_q[cnt]);
    ha2       = half_add(ha1[0], carry);
    bit_sum   = ha2[0];
    carry_nxt = ha1[1] | ha2[1];
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result shifts in from the MSB so the LSB computed first ends at bit 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      res    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        RUN: begin
          res   <= {bit_sum, res[WIDTH-1:1]};
          carry <= carry_nxt;
          if (last_bit) cout_q <= carry_nxt;
          else          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

`ifdef SERIAL_ADD_OVERFLOW_EN
  logic ovf_q;

  // Carry into the MSB is the registered carry during the last bit
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state == RUN && last_bit) ovf_q <= carry ^ carry_nxt;
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized self-checking bench for serial_add_sequencer (WIDTH=8) against a
// plain-arithmetic reference model.
module tb_serial_add_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, carry_out, busy;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int failures = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
`ifdef SERIAL_ADD_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer addition and sign-rule overflow
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s;
    s = x + y;
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Presents one operand pair, returns the cycle in which out_valid first rose
  // (handshake cycle = 0), or -1 if it never did within the bound.
  task automatic start_and_wait(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
`ifdef SERIAL_ADD_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_and_wait(8'h0F, 8'h01, lat);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
    checks++; if (sum !== 8'h10) begin failures++; $display("FAIL basic_sum got=%h exp=10", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL basic_carry got=%b exp=0", carry_out); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_return_idle in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] xs [4] = '{8'hFF, 8'h7F, 8'h80, 8'h00};
    logic [W-1:0] ys [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
    logic [W:0]   e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(xs[i], ys[i], lat);
      e = ref_add(xs[i], ys[i]);
      checks++; if (lat != W + 1 || sum !== e[W-1:0] || carry_out !== e[W]) begin
        failures++; $display("FAIL corner_%0d lat=%0d sum=%h cout=%b exp lat=%0d sum=%h cout=%b",
                             i, lat, sum, carry_out, W + 1, e[W-1:0], e[W]);
      end
`ifdef SERIAL_ADD_OVERFLOW_EN
      checks++; if (overflow !== ref_ovf(xs[i], ys[i])) begin
        failures++; $display("FAIL corner_ovf_%0d got=%b exp=%b", i, overflow, ref_ovf(xs[i], ys[i]));
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic [W:0]   e;
    int lat;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom);
      out_ready = 1'b1;
      start_and_wait(x, y, lat);
      e = ref_add(x, y);
      checks++; if (lat != W + 1 || sum !== e[W-1:0] || carry_out !== e[W]) begin
        failures++; $display("FAIL random_%0d %h+%h lat=%0d sum=%h cout=%b exp sum=%h cout=%b",
                             i, x, y, lat, sum, carry_out, e[W-1:0], e[W]);
      end
`ifdef SERIAL_ADD_OVERFLOW_EN
      checks++; if (overflow !== ref_ovf(x, y)) begin
        failures++; $display("FAIL random_ovf_%0d got=%b exp=%b", i, overflow, ref_ovf(x, y));
      end
`endif
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y;
    logic [W:0]   e;
    int lat;
    x = W'($urandom); y = W'($urandom);
    e = ref_add(x, y);
    out_ready = 1'b0;
    start_and_wait(x, y, lat);
    checks++; if (lat != W + 1) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, W + 1); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2 == 0);
      a = W'($urandom); b = W'($urandom);
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[W-1:0] || carry_out !== e[W]) begin
        failures++; $display("FAIL bp_hold_%0d ov=%b ir=%b sum=%h cout=%b exp ov=1 ir=0 sum=%h cout=%b",
                             i, out_valid, in_ready, sum, carry_out, e[W-1:0], e[W]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release ir=%b ov=%b exp=1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_queue_%0d busy=%b exp=0", i, busy); end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen;
    out_ready = 1'b1;
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_idle ir=%b ov=%b busy=%b exp=1/0/0", in_ready, out_valid, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=%b exp=0", seen); end
    start_and_wait(8'h12, 8'h34, lat);
    checks++; if (lat != W + 1 || sum !== 8'h46 || carry_out !== 1'b0) begin
      failures++; $display("FAIL midrst_next lat=%0d sum=%h cout=%b exp lat=%0d sum=46 cout=0", lat, sum, carry_out, W + 1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [3];
    logic [W-1:0] ys [3];
    logic [W:0]   e;
    int idx, nres, last;
    logic hs;
    for (int i = 0; i < 3; i++) begin xs[i] = W'($urandom); ys[i] = W'($urandom); end
    out_ready = 1'b1;
    idx = 0; nres = 0; last = 0;
    a = xs[0]; b = ys[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        e = ref_add(xs[nres % 3], ys[nres % 3]);
        checks++; if (nres > 2 || sum !== e[W-1:0] || carry_out !== e[W]) begin
          failures++; $display("FAIL b2b_result_%0d sum=%h cout=%b exp sum=%h cout=%b", nres, sum, carry_out, e[W-1:0], e[W]);
        end
        checks++; if (nres > 0 && cyc - last != W + 2) begin
          failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", nres, cyc - last, W + 2);
        end
        last = cyc;
        nres++;
      end
      hs = in_ready && in_valid;
      tick();
      if (hs) begin
        idx++;
        if (idx < 3) begin a = xs[idx]; b = ys[idx]; end
        else in_valid = 1'b0;
      end
    end
    checks++; if (nres != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nres); end
    checks++; if (last != 3 * (W + 2) - 1) begin failures++; $display("FAIL b2b_last_cycle got=%0d exp=%0d", last, 3 * (W + 2) - 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
